// File: rtl/kfx86_mul_div_pkg.sv
// Shared types for the kfx86 multiply/divide unit.
package kfx86_mul_div_pkg;

    // Arithmetic status flags carried through the unit.
    typedef struct packed {
        logic o;
        logic s;
        logic z;
        logic a;
        logic p;
        logic c;
    } flags_t;

endpackage

// File: rtl/kfx86_mul_div.sv
// kfx86 multi-cycle MUL/IMUL/DIV/IDIV unit, byte and word forms.
// Signed operations are reduced to magnitudes (one spare bit so 0x80/0x8000
// never overflow), iterated one bit per cycle, then sign-corrected.
module kfx86_mul_div
    import kfx86_mul_div_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  opcode,
    input  logic        select_word,
    input  logic [31:0] acc_in,
    input  logic [15:0] operand,
    input  flags_t      source_flags,
    output logic        busy,
    output logic        done,
    output logic        div_error,
    output logic [15:0] result_low,
    output logic [15:0] result_high,
    output flags_t      out_flags
);

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    // Captured request.
    logic [1:0]  r_opcode;
    logic        r_word;
    logic [31:0] r_acc_in;
    logic [15:0] r_operand;
    flags_t      r_src_flags;

    // Iteration datapath: r_mag is multiplicand or divisor magnitude,
    // r_shift is multiplier or dividend-low/quotient, r_acc is product or remainder.
    logic [16:0] r_mag;
    logic [15:0] r_shift;
    logic [31:0] r_acc;
    logic [3:0]  r_count;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_ovf;

    // Registered results.
    logic        r_div_error;
    logic [15:0] r_result_low;
    logic [15:0] r_result_high;
    flags_t      r_out_flags;

    logic        w_is_div;
    logic        w_signed;
    logic        w_last_iter;
    logic        w_div_zero;

    logic [16:0] w_a_val;
    logic [16:0] w_a_mag;
    logic [16:0] w_o_val;
    logic [16:0] w_o_mag;
    logic [32:0] w_dd_val;
    logic [31:0] w_dd_mag;
    logic [15:0] w_dd_hi;
    logic [15:0] w_dd_lo;
    logic        w_div_ovf;

    logic [31:0] w_mul_next;
    logic [16:0] w_trial;
    logic        w_q_bit;
    logic [16:0] w_rem_next;

    logic [31:0] w_prod;
    logic        w_mul_ovf;
    logic [15:0] w_quo;
    logic [15:0] w_rem;
    logic        w_div_err;
    flags_t      w_fix_flags;

    assign w_is_div    = r_opcode[1];
    assign w_signed    = r_opcode[0];
    assign w_last_iter = (r_count == (r_word ? 4'd15 : 4'd7));
    assign w_div_zero  = w_is_div && (w_o_mag == 17'd0);

    assign div_error   = r_div_error;
    assign result_low  = r_result_low;
    assign result_high = r_result_high;
    assign out_flags   = r_out_flags;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and status outputs.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (which would infer a latch).
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: if (start) w_next = PREP;
            PREP: begin
                busy   = 1'b1;
                w_next = w_div_zero ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (w_last_iter) w_next = FIX;
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand sign extension and magnitude conversion used in PREP.
    always_comb begin
        w_a_val  = r_word ? {w_signed & r_acc_in[15], r_acc_in[15:0]}
                          : {{9{w_signed & r_acc_in[7]}}, r_acc_in[7:0]};
        w_o_val  = r_word ? {w_signed & r_operand[15], r_operand}
                          : {{9{w_signed & r_operand[7]}}, r_operand[7:0]};
        w_dd_val = r_word ? {w_signed & r_acc_in[31], r_acc_in}
                          : {{17{w_signed & r_acc_in[15]}}, r_acc_in[15:0]};
        w_a_mag  = w_a_val[16] ? (17'd0 - w_a_val) : w_a_val;
        w_o_mag  = w_o_val[16] ? (17'd0 - w_o_val) : w_o_val;
        w_dd_mag = w_dd_val[32] ? (32'd0 - w_dd_val[31:0]) : w_dd_val[31:0];
        w_dd_hi  = r_word ? w_dd_mag[31:16] : {8'h00, w_dd_mag[15:8]};
        w_dd_lo  = r_word ? w_dd_mag[15:0]  : {w_dd_mag[7:0], 8'h00};
        // A quotient fits in W bits only if the dividend's upper half is below the divisor.
        w_div_ovf = ({1'b0, w_dd_hi} >= w_o_mag);
    end

    // One shift-add or restoring shift-subtract step.
    always_comb begin
        w_mul_next = (r_acc << 1) + (r_shift[15] ? {15'h0000, r_mag} : 32'h0000_0000);
        w_trial    = {r_acc[15:0], r_shift[15]};
        w_q_bit    = (w_trial >= r_mag);
        w_rem_next = w_q_bit ? (w_trial - r_mag) : w_trial;
    end

    // Sign correction and flag derivation applied in FIX.
    always_comb begin
        w_prod      = r_neg_q ? (32'd0 - r_acc) : r_acc;
        w_quo       = r_neg_q ? (16'd0 - r_shift) : r_shift;
        w_rem       = r_neg_r ? (16'd0 - r_acc[15:0]) : r_acc[15:0];
        if (r_word)
            w_mul_ovf = w_signed ? (w_prod[31:16] != {16{w_prod[15]}}) : (w_prod[31:16] != 16'h0000);
        else
            w_mul_ovf = w_signed ? (w_prod[15:8] != {8{w_prod[7]}}) : (w_prod[15:8] != 8'h00);
        // Signed quotients are limited to +/-127 or +/-32767, so the magnitude MSB must be clear.
        w_div_err   = r_ovf | (w_signed & (r_word ? r_shift[15] : r_shift[7]));
        w_fix_flags = r_src_flags;
        if (!w_is_div) begin
            w_fix_flags.c = w_mul_ovf;
            w_fix_flags.o = w_mul_ovf;
        end
    end

    // Request capture, operand preparation and iteration.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_opcode    <= 2'b00;
            r_word      <= 1'b0;
            r_acc_in    <= 32'h0;
            r_operand   <= 16'h0;
            r_src_flags <= '0;
            r_mag       <= 17'h0;
            r_shift     <= 16'h0;
            r_acc       <= 32'h0;
            r_count     <= 4'd0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_opcode    <= opcode;
                    r_word      <= select_word;
                    r_acc_in    <= acc_in;
                    r_operand   <= operand;
                    r_src_flags <= source_flags;
                end
                PREP: begin
                    r_count <= 4'd0;
                    if (w_is_div) begin
                        r_mag   <= w_o_mag;
                        r_shift <= w_dd_lo;
                        r_acc   <= {16'h0000, w_dd_hi};
                        r_neg_q <= w_dd_val[32] ^ w_o_val[16];
                        r_neg_r <= w_dd_val[32];
                        r_ovf   <= w_div_ovf;
                    end else begin
                        r_mag   <= w_a_mag;
                        r_shift <= r_word ? w_o_mag[15:0] : {w_o_mag[7:0], 8'h00};
                        r_acc   <= 32'h0;
                        r_neg_q <= w_a_val[16] ^ w_o_val[16];
                        r_neg_r <= 1'b0;
                        r_ovf   <= 1'b0;
                    end
                end
                CALC: begin
                    r_count <= r_count + 4'd1;
                    if (w_is_div) begin
                        r_acc   <= {15'h0000, w_rem_next};
                        r_shift <= {r_shift[14:0], w_q_bit};
                    end else begin
                        r_acc   <= w_mul_next;
                        r_shift <= r_shift << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result registers: written only on entry to DONE, held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_div_error   <= 1'b0;
            r_result_low  <= 16'h0;
            r_result_high <= 16'h0;
            r_out_flags   <= '0;
        end else if (r_state == PREP && w_div_zero) begin
            r_div_error   <= 1'b1;
            r_result_low  <= 16'h0;
            r_result_high <= 16'h0;
            r_out_flags   <= r_src_flags;
        end else if (r_state == FIX) begin
            r_out_flags <= w_fix_flags;
            if (w_is_div && w_div_err) begin
                r_div_error   <= 1'b1;
                r_result_low  <= 16'h0;
                r_result_high <= 16'h0;
            end else if (w_is_div) begin
                r_div_error   <= 1'b0;
                r_result_low  <= r_word ? w_quo : {w_rem[7:0], w_quo[7:0]};
                r_result_high <= r_word ? w_rem : 16'h0;
            end else begin
                r_div_error   <= 1'b0;
                r_result_low  <= w_prod[15:0];
                r_result_high <= r_word ? w_prod[31:16] : 16'h0;
            end
        end
    end

endmodule

// File: tb/tb_kfx86_mul_div.sv
// Bench for kfx86_mul_div: directed vector table, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_kfx86_mul_div;
    import kfx86_mul_div_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  opcode = 2'b00;
    logic        select_word = 1'b0;
    logic [31:0] acc_in = 32'h0;
    logic [15:0] operand = 16'h0;
    flags_t      source_flags = '0;
    logic        busy;
    logic        done;
    logic        div_error;
    logic [15:0] result_low;
    logic [15:0] result_high;
    flags_t      out_flags;

    kfx86_mul_div dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .opcode       (opcode),
        .select_word  (select_word),
        .acc_in       (acc_in),
        .operand      (operand),
        .source_flags (source_flags),
        .busy         (busy),
        .done         (done),
        .div_error    (div_error),
        .result_low   (result_low),
        .result_high  (result_high),
        .out_flags    (out_flags)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        err;
        logic [15:0] lo;
        logic [15:0] hi;
        logic [5:0]  fl;
        int          lat;
    } res_t;

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [31:0] acc;
        logic [15:0] opd;
        logic [5:0]  sf;
        res_t        exp;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic w, input logic [31:0] acc,
                                input logic [15:0] opd, input logic [5:0] sf, input logic err,
                                input logic [15:0] lo, input logic [15:0] hi,
                                input logic [5:0] fl, input int lat);
        vec_t v;
        v.op = op; v.w = w; v.acc = acc; v.opd = opd; v.sf = sf;
        v.exp.err = err; v.exp.lo = lo; v.exp.hi = hi; v.exp.fl = fl; v.exp.lat = lat;
        return v;
    endfunction

    // Reference: plain integer arithmetic on sign/zero-extended operands.
    function automatic res_t model(input logic [1:0] op, input logic w, input logic [31:0] acc,
                                   input logic [15:0] opd, input logic [5:0] sf);
        res_t   e;
        longint a, b, p, q, r, lim;
        logic   ovf;
        int     bits;
        bits  = w ? 16 : 8;
        lim   = longint'(1) << (bits - 1);
        e.err = 1'b0; e.lo = 16'h0; e.hi = 16'h0; e.fl = sf; e.lat = bits + 3;
        if (!op[1]) begin
            if (op[0]) begin
                a = w ? longint'($signed(acc[15:0])) : longint'($signed(acc[7:0]));
                b = w ? longint'($signed(opd))       : longint'($signed(opd[7:0]));
                p = a * b;
                ovf = (p < -lim) || (p >= lim);
            end else begin
                a = w ? longint'(acc[15:0]) : longint'(acc[7:0]);
                b = w ? longint'(opd)       : longint'(opd[7:0]);
                p = a * b;
                ovf = (p >= (longint'(1) << bits));
            end
            e.lo = p[15:0];
            if (w) e.hi = p[31:16];
            e.fl[5] = ovf;
            e.fl[0] = ovf;
        end else begin
            if (op[0]) begin
                a = w ? longint'($signed(acc)) : longint'($signed(acc[15:0]));
                b = w ? longint'($signed(opd)) : longint'($signed(opd[7:0]));
            end else begin
                a = w ? longint'(acc) : longint'(acc[15:0]);
                b = w ? longint'(opd) : longint'(opd[7:0]);
            end
            if (b == 0) begin
                e.err = 1'b1;
                e.lat = 2;
            end else begin
                q = a / b;
                r = a % b;
                if (op[0]) ovf = (q > lim - 1) || (q < -(lim - 1));
                else       ovf = (q > (longint'(1) << bits) - 1);
                if (ovf) e.err = 1'b1;
                else if (w) begin
                    e.lo = q[15:0];
                    e.hi = r[15:0];
                end else begin
                    e.lo = {r[7:0], q[7:0]};
                end
            end
        end
        return e;
    endfunction

    // Issue one request and wait (bounded) for done; latency counts the accepting edge as cycle 0.
    task automatic run_op(input logic [1:0] op, input logic w, input logic [31:0] acc,
                          input logic [15:0] opd, input logic [5:0] sf, output res_t got);
        @(negedge clock);
        opcode = op; select_word = w; acc_in = acc; operand = opd;
        source_flags = flags_t'(sf); start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        got.lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                got.lat = c;
                break;
            end
        end
        got.err = div_error; got.lo = result_low; got.hi = result_high; got.fl = out_flags;
    endtask

    task automatic compare(input string tag, input res_t got, input res_t exp);
        check({tag, " div_error"},   32'(got.err), 32'(exp.err));
        check({tag, " result_low"},  32'(got.lo),  32'(exp.lo));
        check({tag, " result_high"}, 32'(got.hi),  32'(exp.hi));
        check({tag, " out_flags"},   32'(got.fl),  32'(exp.fl));
        check({tag, " latency"},     got.lat,      exp.lat);
    endtask

    localparam logic [5:0] SF1 = 6'b010101;
    localparam logic [5:0] SF2 = 6'b101010;

    initial begin
        vec_t        vecs[16];
        res_t        got;
        res_t        exp;
        int          n_done;
        int          first_done;
        logic [1:0]  r_op;
        logic        r_w;
        logic [31:0] r_acc;
        logic [15:0] r_opd;
        logic [5:0]  r_sf;

        //             op     w     acc            opd       sf   err  lo        hi        flags      lat
        vecs[0]  = mk(2'b00, 1'b0, 32'h0000_0012, 16'h0034, SF1, 1'b0, 16'h03A8, 16'h0000, 6'b110101, 11);
        vecs[1]  = mk(2'b01, 1'b1, 32'h0000_FFFF, 16'h0002, SF2, 1'b0, 16'hFFFE, 16'hFFFF, 6'b001010, 19);
        vecs[2]  = mk(2'b10, 1'b1, 32'h0001_0000, 16'h0010, SF2, 1'b0, 16'h1000, 16'h0000, SF2,       19);
        vecs[3]  = mk(2'b10, 1'b1, 32'h0001_0000, 16'h0000, SF1, 1'b1, 16'h0000, 16'h0000, SF1,        2);
        vecs[4]  = mk(2'b11, 1'b0, 32'h0000_FF9C, 16'h0007, SF2, 1'b0, 16'hFEF2, 16'h0000, SF2,       11);
        vecs[5]  = mk(2'b11, 1'b0, 32'h0000_0100, 16'h0001, SF1, 1'b1, 16'h0000, 16'h0000, SF1,       11);
        vecs[6]  = mk(2'b01, 1'b0, 32'hABCD_0080, 16'hFF80, SF1, 1'b0, 16'h4000, 16'h0000, 6'b110101, 11);
        vecs[7]  = mk(2'b11, 1'b0, 32'h0000_FF80, 16'h0001, SF2, 1'b1, 16'h0000, 16'h0000, SF2,       11);
        vecs[8]  = mk(2'b11, 1'b0, 32'h1234_FF81, 16'h0001, SF1, 1'b0, 16'h0081, 16'h0000, SF1,       11);
        vecs[9]  = mk(2'b11, 1'b1, 32'hFFFF_8000, 16'hFFFF, SF2, 1'b1, 16'h0000, 16'h0000, SF2,       19);
        vecs[10] = mk(2'b00, 1'b1, 32'h0000_FFFF, 16'hFFFF, SF2, 1'b0, 16'h0001, 16'hFFFE, 6'b101011, 19);
        vecs[11] = mk(2'b10, 1'b0, 32'h0000_0100, 16'h0002, SF1, 1'b0, 16'h0080, 16'h0000, SF1,       11);
        vecs[12] = mk(2'b01, 1'b1, 32'h0000_8000, 16'h8000, SF2, 1'b0, 16'h0000, 16'h4000, 6'b101011, 19);
        vecs[13] = mk(2'b01, 1'b0, 32'h0000_0005, 16'h0000, SF1, 1'b0, 16'h0000, 16'h0000, 6'b010100, 11);
        vecs[14] = mk(2'b10, 1'b0, 32'h0000_0064, 16'h0000, SF2, 1'b1, 16'h0000, 16'h0000, SF2,        2);
        vecs[15] = mk(2'b11, 1'b1, 32'hFFFF_FF9C, 16'h0007, SF1, 1'b0, 16'hFFF2, 16'hFFFE, SF1,       19);

        // Reset state, held and after release.
        #12;
        check("reset busy",        32'(busy),        32'h0);
        check("reset done",        32'(done),        32'h0);
        check("reset div_error",   32'(div_error),   32'h0);
        check("reset result_low",  32'(result_low),  32'h0);
        check("reset result_high", 32'(result_high), 32'h0);
        check("reset out_flags",   32'(out_flags),   32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("idle busy", 32'(busy), 32'h0);

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].w, vecs[i].acc, vecs[i].opd, vecs[i].sf, got);
            compare($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Results hold in IDLE after completion.
        repeat (3) @(negedge clock);
        check("hold result_low",  32'(result_low),  32'(vecs[15].exp.lo));
        check("hold result_high", 32'(result_high), 32'(vecs[15].exp.hi));

        // Start pulses in cycles 3 and 11 of a byte MUL are ignored.
        @(negedge clock);
        opcode = 2'b00; select_word = 1'b0; acc_in = 32'h12; operand = 16'h34;
        source_flags = flags_t'(SF1); start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n_done = 0;
        first_done = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clock);
            if (c == 1)  check("busy in cycle 1", 32'(busy), 32'h1);
            if (c == 11) check("busy low with done", 32'(busy), 32'h0);
            if (done === 1'b1) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            if (c == 3 || c == 11) start = 1'b1;
            if (c == 4 || c == 12) start = 1'b0;
        end
        check("ignored start done count", n_done, 1);
        check("ignored start done cycle", first_done, 11);
        check("ignored start result_low", 32'(result_low), 32'h03A8);

        // Reset asserted in cycle 5 of a byte MUL.
        @(negedge clock);
        opcode = 2'b00; select_word = 1'b0; acc_in = 32'h55; operand = 16'h66;
        source_flags = flags_t'(SF2); start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        check("mid-op busy", 32'(busy), 32'h1);
        check("mid-op result held", 32'(result_low), 32'h03A8);
        reset_n = 1'b0;
        #1;
        check("async reset busy",        32'(busy),        32'h0);
        check("async reset done",        32'(done),        32'h0);
        check("async reset div_error",   32'(div_error),   32'h0);
        check("async reset result_low",  32'(result_low),  32'h0);
        check("async reset result_high", 32'(result_high), 32'h0);
        check("async reset out_flags",   32'(out_flags),   32'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done === 1'b1) n_done++;
        end
        check("no done after reset", n_done, 0);
        check("no partial result", 32'(result_low), 32'h0);

        // First start after reset is accepted normally.
        run_op(2'b00, 1'b0, 32'h55, 16'h66, SF2, got);
        exp = model(2'b00, 1'b0, 32'h55, 16'h66, SF2);
        compare("post-reset", got, exp);
        check("post-reset product", 32'(got.lo), 32'h21DE);

        // Random operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_w   = 1'($urandom_range(0, 1));
            r_acc = $urandom;
            r_opd = 16'($urandom);
            r_sf  = 6'($urandom);
            if (r_op[1] && $urandom_range(0, 1) == 1) begin
                r_acc = r_acc >> $urandom_range(0, 31);
                if (r_op[0] && $urandom_range(0, 1) == 1) r_acc = 32'd0 - r_acc;
            end
            if ($urandom_range(0, 15) == 0)     r_opd = 16'h0000;
            else if ($urandom_range(0, 3) == 0) r_opd = 16'($urandom_range(1, 15));
            exp = model(r_op, r_w, r_acc, r_opd, r_sf);
            run_op(r_op, r_w, r_acc, r_opd, r_sf, got);
            compare($sformatf("rnd%0d op=%0d w=%0d acc=%h opd=%h", i, r_op, r_w, r_acc, r_opd), got, exp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/kfx86_mul_div.md
KFX86_MUL_DIV -- requirements
Module: kfx86_mul_div

Interface
REQ-001 The block SHALL expose these ports, clock and reset first, as: name  direction  width  meaning.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- opcode  in  2  00 MUL, 01 IMUL, 10 DIV, 11 IDIV.
- select_word  in  1  0 = byte operation, 1 = word operation.
- acc_in  in  32  DX:AX image.
- operand  in  16  source operand; byte operations use [7:0].
- source_flags  in  flags_t  flags before the operation.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  single-cycle completion pulse.
- div_error  out  1  divide error, valid with done, held until next acceptance.
- result_low  out  16  AX image.
- result_high  out  16  DX image.
- out_flags  out  flags_t  flags after the operation.

REQ-002 The block SHALL have no parameters; widths are fixed as listed.

Function
REQ-003 Operand mapping SHALL be:
- byte MUL/IMUL: multiplicand acc_in[7:0]; result_low = 16-bit product; result_high = 0.
- word MUL/IMUL: multiplicand acc_in[15:0]; {result_high, result_low} = 32-bit product.
- byte DIV/IDIV: dividend acc_in[15:0]; result_low = {remainder8, quotient8}; result_high = 0.
- word DIV/IDIV: dividend acc_in[31:0]; result_low = quotient; result_high = remainder.

REQ-004 The state machine SHALL use states IDLE, PREP, CALC, FIX and DONE.
- IDLE -> PREP on start; opcode, select_word, acc_in, operand and source_flags are captured on that edge.
- PREP -> CALC, or PREP -> DONE on divide-by-zero.
- CALC -> FIX after W iterations (W = 8 byte, 16 word).
- FIX -> DONE.
- DONE -> IDLE unconditionally.

REQ-005 Algorithm and signed handling:
- CALC SHALL perform one radix-2 shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle.
- IMUL/IDIV SHALL convert operands to magnitudes in PREP and apply sign correction in FIX.

REQ-006 Latency SHALL be exact. With the accepting edge as cycle 0, done is high in cycle W+3 (byte 11, word 19); divide-by-zero gives done in cycle 2.

REQ-007 start SHALL be ignored while busy or done is high; there is no queueing.

REQ-008 result_low, result_high, out_flags and div_error SHALL update only on entry to DONE and hold until the next accepted start.

REQ-009 Multiply flags:
- MUL: c = o = (upper half of product != 0).
- IMUL: c = o = (upper half != sign-extension of lower half).
- All other flag fields SHALL equal captured source_flags.

REQ-010 Divide flags: out_flags SHALL equal captured source_flags.

REQ-011 div_error SHALL assert with done when any of these holds; results are then 0 and out_flags = source_flags:
- divisor == 0;
- unsigned quotient exceeds 0xFF (byte) or 0xFFFF (word);
- signed quotient is outside -127..+127 (byte) or -32767..+32767 (word).

REQ-012 IDIV sign rules: quotient SHALL truncate toward zero; remainder SHALL take the dividend's sign.

REQ-013 The 0x80/0x8000 operand magnitude SHALL be handled without overflow inside the datapath (one extra magnitude bit).

Reset
REQ-014 reset_n low SHALL immediately force IDLE and set busy = 0, done = 0, div_error = 0, result_low = 0, result_high = 0, out_flags = all zero, including mid-operation.

REQ-015 After reset_n deasserts, the first start sampled high SHALL be accepted; no partial prior result shall appear.

Verification
REQ-016 Byte MUL: acc_in[7:0] = 0x12, operand 0x34 -> result_low 0x03A8, result_high 0, c = o = 1, done in cycle 11.

REQ-017 Word IMUL: acc_in[15:0] = 0xFFFF, operand 0x0002 -> result_high 0xFFFF, result_low 0xFFFE, c = o = 0, done in cycle 19.

REQ-018 Word DIV: acc_in = 0x00010000, operand 0x0010 -> result_low 0x1000, result_high 0x0000, div_error 0; then operand 0x0000 -> div_error 1, done in cycle 2.

REQ-019 Byte IDIV: acc_in[15:0] = 0xFF9C (-100), operand 0x07 -> result_low 0xFEF2 (quotient -14, remainder -2); acc_in[15:0] = 0x0100, operand 0x01 -> div_error 1, results 0.

REQ-020 Start while busy, and reset during CALC:
- start pulsed in cycles 3 and 11 of a byte MUL -> ignored, single done in cycle 11.
- reset_n low in cycle 5 -> busy 0 and outputs 0 immediately, no done.
